// File: rtl/sext_arbiter.sv
// Two-requester immediate sign/zero-extension unit with a registered, one-cycle-latency result.
// Optional macro SEXT_ARB_RR_EN selects round-robin arbitration; otherwise requester 0 has fixed priority.
module sext_arbiter #(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [10:0]      req0_imm,
  input  logic [1:0]       req0_mode,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [10:0]      req1_imm,
  input  logic [1:0]       req1_mode,
  output logic             req1_ready,
  input  logic             flush,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [OUT_W-1:0] resp_data
);

  logic             grant0;
  logic             grant1;
  logic [10:0]      sel_imm;
  logic [1:0]       sel_mode;
  logic [OUT_W-1:0] ext_data;
  logic             resp0_reg;
  logic             resp1_reg;
  logic [OUT_W-1:0] data_reg;

  function automatic logic [OUT_W-1:0] extend(input logic [10:0] imm, input logic [1:0] mode);
    case (mode)
      2'b00:   extend = {{(OUT_W-5){imm[4]}}, imm[4:0]};
      2'b01:   extend = {{(OUT_W-8){imm[7]}}, imm[7:0]};
      2'b10:   extend = {{(OUT_W-11){imm[10]}}, imm[10:0]};
      default: extend = {{(OUT_W-8){1'b0}}, imm[7:0]};
    endcase
  endfunction

`ifdef SEXT_ARB_RR_EN
  // Remembers the requester granted most recently; reset value makes requester 0 win first.
  logic last_grant_reg;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !flush) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_reg;
        grant1 = !last_grant_reg;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else if (grant0) begin
      last_grant_reg <= 1'b0;
    end else if (grant1) begin
      last_grant_reg <= 1'b1;
    end
  end
`else
  always_comb begin
    grant0 = req0_valid && !rst && !flush;
    grant1 = req1_valid && !req0_valid && !rst && !flush;
  end
`endif

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    sel_imm  = grant1 ? req1_imm : req0_imm;
    sel_mode = grant1 ? req1_mode : req0_mode;
    ext_data = extend(sel_imm, sel_mode);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp0_reg <= 1'b0;
      resp1_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      resp0_reg <= grant0;
      resp1_reg <= grant1;
      if (grant0 || grant1) begin
        data_reg <= ext_data;
      end
    end
  end

  // Gating with rst hides a result accepted just before reset was raised.
  assign resp0_valid = resp0_reg && !rst;
  assign resp1_valid = resp1_reg && !rst;
  assign resp_data   = rst ? '0 : data_reg;

endmodule

// File: tb/tb_sext_arbiter.sv
// Directed self-checking bench for sext_arbiter; expectations for contested cycles follow SEXT_ARB_RR_EN.
module tb_sext_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [10:0] req0_imm;
  logic [1:0]  req0_mode;
  logic        req0_ready;
  logic        req1_valid;
  logic [10:0] req1_imm;
  logic [1:0]  req1_mode;
  logic        req1_ready;
  logic        flush;
  logic        resp0_valid;
  logic        resp1_valid;
  logic [15:0] resp_data;

  int compared = 0;
  int mismatched = 0;

  sext_arbiter #(.OUT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_imm(req0_imm), .req0_mode(req0_mode), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_imm(req1_imm), .req1_mode(req1_mode), .req1_ready(req1_ready),
    .flush(flush),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_data(resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Applies one cycle of inputs at the falling edge; checks follow 1 time unit later.
  task automatic drive(input logic r, input logic f,
                       input logic v0, input logic [10:0] i0, input logic [1:0] m0,
                       input logic v1, input logic [10:0] i1, input logic [1:0] m1);
    @(negedge clk);
    rst = r; flush = f;
    req0_valid = v0; req0_imm = i0; req0_mode = m0;
    req1_valid = v1; req1_imm = i1; req1_mode = m1;
    #1;
  endtask

  task automatic chk_resp(input string tag, input logic e0, input logic e1, input logic [15:0] ed);
    chk({tag, "_rv0"}, {15'd0, resp0_valid}, {15'd0, e0});
    chk({tag, "_rv1"}, {15'd0, resp1_valid}, {15'd0, e1});
    chk({tag, "_data"}, resp_data, ed);
  endtask

  task automatic chk_ready(input string tag, input logic e0, input logic e1);
    chk({tag, "_rdy0"}, {15'd0, req0_ready}, {15'd0, e0});
    chk({tag, "_rdy1"}, {15'd0, req1_ready}, {15'd0, e1});
  endtask

  logic exp_g [4];

  initial begin
`ifdef SEXT_ARB_RR_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    rst = 1'b1; flush = 1'b0;
    req0_valid = 1'b0; req0_imm = '0; req0_mode = '0;
    req1_valid = 1'b0; req1_imm = '0; req1_mode = '0;
    repeat (2) @(posedge clk);

    // Reset dominates a request and flush
    drive(1, 1, 1, 11'h010, 2'b00, 1, 11'h010, 2'b00);
    chk_ready("rst", 0, 0);
    chk_resp("rst", 0, 0, 16'h0000);

    drive(0, 0, 1, 11'h010, 2'b00, 0, 11'h000, 2'b00);
    chk_ready("r0_a", 1, 0);
    chk_resp("r0_a", 0, 0, 16'h0000);
    drive(0, 0, 1, 11'h00F, 2'b00, 0, 11'h000, 2'b00);
    chk_ready("r0_b", 1, 0);
    chk_resp("r0_b", 1, 0, 16'hFFF0);
    drive(0, 0, 0, 11'h7FF, 2'b11, 1, 11'h080, 2'b01);
    chk_ready("r1_a", 0, 1);
    chk_resp("r1_a", 1, 0, 16'h000F);
    drive(0, 0, 0, 11'h000, 2'b00, 1, 11'h400, 2'b10);
    chk_resp("r1_b", 0, 1, 16'hFF80);
    drive(0, 0, 0, 11'h000, 2'b00, 1, 11'h7FF, 2'b11);
    chk_resp("r1_c", 0, 1, 16'hFC00);
    drive(0, 0, 0, 11'h000, 2'b00, 0, 11'h000, 2'b00);
    chk_ready("idle_a", 0, 0);
    chk_resp("idle_a", 0, 1, 16'h00FF);
    drive(0, 0, 1, 11'h7EF, 2'b00, 0, 11'h000, 2'b00);
    chk_resp("idle_b", 0, 0, 16'h00FF);
    drive(0, 0, 1, 11'h07F, 2'b01, 0, 11'h000, 2'b00);
    chk_resp("upper_ign", 1, 0, 16'h000F);

    // Flush after an acceptance: response still appears, nothing accepted
    drive(0, 1, 0, 11'h000, 2'b00, 1, 11'h001, 2'b00);
    chk_ready("flush", 0, 0);
    chk_resp("flush", 1, 0, 16'h007F);
    drive(0, 0, 0, 11'h000, 2'b00, 0, 11'h000, 2'b00);
    chk_resp("post_flush", 0, 0, 16'h007F);

    // Reset right after an acceptance suppresses the response
    drive(0, 0, 1, 11'h3FF, 2'b10, 0, 11'h000, 2'b00);
    chk_ready("pre_rst", 1, 0);
    drive(1, 0, 0, 11'h000, 2'b00, 0, 11'h000, 2'b00);
    chk_ready("mid_rst", 0, 0);
    chk_resp("mid_rst", 0, 0, 16'h0000);

    // Contested cycles straight after reset release
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 1, 11'h001, 2'b00, 1, 11'h01F, 2'b00);
      chk_ready($sformatf("arb%0d", c), !exp_g[c], exp_g[c]);
      if (c == 0) chk_resp("arb0", 0, 0, 16'h0000);
      else chk_resp($sformatf("arb%0d", c), !exp_g[c-1], exp_g[c-1], exp_g[c-1] ? 16'hFFFF : 16'h0001);
    end
    // Flush while contested must not move the pointer
    drive(0, 1, 1, 11'h001, 2'b00, 1, 11'h01F, 2'b00);
    chk_ready("arb_flush", 0, 0);
    chk_resp("arb4", !exp_g[3], exp_g[3], exp_g[3] ? 16'hFFFF : 16'h0001);
    drive(0, 0, 1, 11'h001, 2'b00, 1, 11'h01F, 2'b00);
    chk_ready("arb_after_flush", 1, 0);
    chk_resp("arb_after_flush", 0, 0, exp_g[3] ? 16'hFFFF : 16'h0001);
    drive(0, 0, 0, 11'h000, 2'b00, 0, 11'h000, 2'b00);
    chk_resp("arb_last", 1, 0, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
